deser_fila_ctrl: RTL and testbench

Transfer controller between the serial deserializer (`Deserializador`) and the byte queue (`Fila`). It takes completed bytes from the deserializer and enqueues them, acknowledging each byte. It throttles the deserializer while the queue is full and schedules consumer reads as dequeue pulses. It keeps an authoritative occupancy count, flags any disagreement with the queue's reported length, and exposes status and drop statistics to the top level.

---
 rtl/deser_fila_ctrl.sv | 167 ++++++++++++++++
 tb/tb_deser_fila_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_fila_ctrl.sv
// deser_fila_ctrl
//   Transfer controller between the serial deserializer and the byte queue.
//   Moves completed bytes from the deserializer into the queue with an
//   acknowledge handshake, throttles serial capture while the queue is full,
//   paces consumer reads as single-cycle dequeue pulses, tracks occupancy
//   and cross-checks it against the queue's own length report.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-low
//   des_data   deserializer byte
//   des_ready  deserializer byte-ready level (held until acknowledged)
//   des_ack    acknowledge to deserializer
//   des_write  serial capture enable to deserializer (low while full)
//   fifo_len   queue's reported length
//   fifo_data  byte to queue
//   fifo_enq   enqueue pulse to queue
//   fifo_deq   dequeue pulse to queue
//   rd_req     consumer read request level
//   rd_valid   queue output valid for consumer (cycle after fifo_deq)
//   occ        internal occupancy 0..DEPTH
//   full       occ == DEPTH
//   empty      occ == 0
//   drop_cnt   discarded bytes, saturating at 255
//   len_err    sticky: fifo_len disagreed with occ on a quiet bus
//   state      IDLE=0, ACK=1, STALL=2
module deser_fila_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LEN_W        = 4,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       des_data,
  input  logic             des_ready,
  output logic             des_ack,
  output logic             des_write,
  input  logic [LEN_W-1:0] fifo_len,
  output logic [7:0]       fifo_data,
  output logic             fifo_enq,
  output logic             fifo_deq,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [LEN_W-1:0] occ,
  output logic             full,
  output logic             empty,
  output logic [7:0]       drop_cnt,
  output logic             len_err,
  output logic [1:0]       state
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           cur_st;
  state_t           nxt_st;
  logic             enq_now;
  logic             deq_now;
  logic             drop_now;
  logic             ack_nxt;
  logic [LEN_W-1:0] occ_next;
  logic             quiet_now;
  logic             quiet_d1;

  assign state = cur_st;

  // Byte transfer FSM. Decisions use the registered full flag, so a dequeue
  // in the same cycle never opens room for an enqueue until the next edge.
  always_comb begin
    nxt_st   = cur_st;
    enq_now  = 1'b0;
    drop_now = 1'b0;
    ack_nxt  = 1'b0;
    unique case (cur_st)
      IDLE: begin
        if (des_ready) begin
          if (!full) begin
            enq_now = 1'b1;
            ack_nxt = 1'b1;
            nxt_st  = ACK;
          end else if (DROP_ON_FULL) begin
            drop_now = 1'b1;
            ack_nxt  = 1'b1;
            nxt_st   = ACK;
          end else begin
            nxt_st = STALL;
          end
        end
      end
      STALL: begin
        if (!full) begin
          enq_now = 1'b1;
          ack_nxt = 1'b1;
          nxt_st  = ACK;
        end
      end
      ACK: begin
        if (des_ready) begin
          ack_nxt = 1'b1;
        end else begin
          nxt_st = IDLE;
        end
      end
      default: nxt_st = IDLE;
    endcase
  end

  // Dequeue pacing: a pulse can only issue when the previous cycle had none.
  assign deq_now = rd_req && !empty && !fifo_deq;

  always_comb begin
    occ_next = occ;
    if (enq_now && !deq_now) begin
      occ_next = occ + LEN_W'(1);
    end else if (!enq_now && deq_now) begin
      occ_next = occ - LEN_W'(1);
    end
  end

  // The queue's length settles one edge after each pulse, so comparison is
  // only meaningful after two pulse-free cycles.
  assign quiet_now = !fifo_enq && !fifo_deq;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_st    <= IDLE;
      occ       <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      des_write <= 1'b0;
      des_ack   <= 1'b0;
      fifo_enq  <= 1'b0;
      fifo_deq  <= 1'b0;
      rd_valid  <= 1'b0;
      fifo_data <= '0;
      drop_cnt  <= '0;
      quiet_d1  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      occ       <= occ_next;
      full      <= (occ_next == DEPTH_L);
      empty     <= (occ_next == '0);
      des_write <= (occ_next != DEPTH_L);
      des_ack   <= ack_nxt;
      fifo_enq  <= enq_now;
      fifo_deq  <= deq_now;
      rd_valid  <= fifo_deq;
      if (enq_now) begin
        fifo_data <= des_data;
      end
      if (drop_now && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      quiet_d1 <= quiet_now;
      if (quiet_now && quiet_d1 && (fifo_len != occ)) begin
        len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deser_fila_ctrl.sv
// Testbench for deser_fila_ctrl: table-driven vectors on a stall-policy
// instance plus hand-written sequences for the length check, reset during
// ACK and the drop policy on a second instance.
module tb_deser_fila_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;

  // Stall-policy instance signals
  logic [7:0] des_data = 8'h00;
  logic       des_ready = 1'b0;
  logic       des_ack, des_write;
  logic [3:0] fifo_len;
  logic [7:0] fifo_data;
  logic       fifo_enq, fifo_deq;
  logic       rd_req = 1'b0;
  logic       rd_valid;
  logic [3:0] occ;
  logic       full, empty;
  logic [7:0] drop_cnt;
  logic       len_err;
  logic [1:0] state;

  // Drop-policy instance signals
  logic [7:0] b_data = 8'h00;
  logic       b_ready = 1'b0;
  logic       b_ack, b_write;
  logic [3:0] b_len;
  logic [7:0] b_fdata;
  logic       b_enq, b_deq;
  logic       b_rd = 1'b0;
  logic       b_valid;
  logic [3:0] b_occ;
  logic       b_full, b_empty;
  logic [7:0] b_drop;
  logic       b_lerr;
  logic [1:0] b_state;

  // Queue length models: count pulses as a real queue would
  logic [3:0] q_len, qb_len;
  logic       force_len = 1'b0;
  logic [3:0] len_val = 4'd0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset) begin
      q_len  <= 4'd0;
      qb_len <= 4'd0;
    end else begin
      q_len  <= q_len + {3'b000, fifo_enq} - {3'b000, fifo_deq};
      qb_len <= qb_len + {3'b000, b_enq} - {3'b000, b_deq};
    end
  end

  assign fifo_len = force_len ? len_val : q_len;
  assign b_len    = qb_len;

  deser_fila_ctrl #(.DEPTH(8), .LEN_W(4), .DROP_ON_FULL(1'b0)) u_dut (
    .clock(clock), .reset(reset),
    .des_data(des_data), .des_ready(des_ready), .des_ack(des_ack),
    .des_write(des_write), .fifo_len(fifo_len), .fifo_data(fifo_data),
    .fifo_enq(fifo_enq), .fifo_deq(fifo_deq), .rd_req(rd_req),
    .rd_valid(rd_valid), .occ(occ), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .len_err(len_err), .state(state)
  );

  deser_fila_ctrl #(.DEPTH(8), .LEN_W(4), .DROP_ON_FULL(1'b1)) u_drop (
    .clock(clock), .reset(reset),
    .des_data(b_data), .des_ready(b_ready), .des_ack(b_ack),
    .des_write(b_write), .fifo_len(b_len), .fifo_data(b_fdata),
    .fifo_enq(b_enq), .fifo_deq(b_deq), .rd_req(b_rd),
    .rd_valid(b_valid), .occ(b_occ), .full(b_full), .empty(b_empty),
    .drop_cnt(b_drop), .len_err(b_lerr), .state(b_state)
  );

  typedef struct {
    logic       rst_n;
    logic       rdy;
    logic       rd;
    logic [7:0] din;
    logic [1:0] st;
    logic       ack;
    logic       enq;
    logic       deq;
    logic       vld;
    logic [3:0] occ;
    logic       full;
    logic       empty;
    logic       wr;
    logic [7:0] fdata;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input int rst_n, input int rdy, input int rd,
                              input int din, input int st, input int ack,
                              input int enq, input int deq, input int vld,
                              input int o, input int fd);
    vec_t v;
    v.rst_n = rst_n[0];
    v.rdy   = rdy[0];
    v.rd    = rd[0];
    v.din   = din[7:0];
    v.st    = st[1:0];
    v.ack   = ack[0];
    v.enq   = enq[0];
    v.deq   = deq[0];
    v.vld   = vld[0];
    v.occ   = o[3:0];
    v.full  = (o == 8);
    v.empty = (o == 0);
    v.wr    = (rst_n != 0) && (o != 8);
    v.fdata = fd[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [20:0] act, exp;
    logic        b_enq_seen;

    // ---- vector table ----
    vecs.push_back(mk(0,0,0,8'h00, 0,0,0,0,0, 0, 8'h00));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,0,0,0, 0, 8'h00));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 0, 8'h00));
    // single byte, des_ready held two cycles
    vecs.push_back(mk(1,1,0,8'hA5, 1,1,1,0,0, 1, 8'hA5));
    vecs.push_back(mk(1,1,0,8'hA5, 1,1,0,0,0, 1, 8'hA5));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 1, 8'hA5));
    // reset, then fill with 0x01..0x08
    vecs.push_back(mk(0,0,0,8'h00, 0,0,0,0,0, 0, 8'h00));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 0, 8'h00));
    for (int b = 1; b <= 8; b++) begin
      vecs.push_back(mk(1,1,0,b,     1,1,1,0,0, b, b));
      vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, b, b));
    end
    // 0x09 stalls, one read releases it
    vecs.push_back(mk(1,1,0,8'h09, 2,0,0,0,0, 8, 8'h08));
    vecs.push_back(mk(1,1,0,8'h09, 2,0,0,0,0, 8, 8'h08));
    vecs.push_back(mk(1,1,1,8'h09, 2,0,0,1,0, 7, 8'h08));
    vecs.push_back(mk(1,1,0,8'h09, 1,1,1,0,1, 8, 8'h09));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 8, 8'h09));
    // drain to 4 with rd_req held: pulses every other cycle
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(1,0,1,8'h00, 0,0,0,1,0, 7-k, 8'h09));
      vecs.push_back(mk(1,0,(k<3)?1:0,8'h00, 0,0,0,0,1, 7-k, 8'h09));
    end
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 4, 8'h09));
    // simultaneous enqueue and dequeue at occ=4
    vecs.push_back(mk(1,1,1,8'h3C, 1,1,1,1,0, 4, 8'h3C));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,1, 4, 8'h3C));
    // drain to empty, then read requests on empty give nothing
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(1,0,1,8'h00, 0,0,0,1,0, 3-k, 8'h3C));
      vecs.push_back(mk(1,0,1,8'h00, 0,0,0,0,1, 3-k, 8'h3C));
    end
    vecs.push_back(mk(1,0,1,8'h00, 0,0,0,0,0, 0, 8'h3C));
    vecs.push_back(mk(1,0,1,8'h00, 0,0,0,0,0, 0, 8'h3C));
    // two bytes to reach occ=2, then a quiet bus
    vecs.push_back(mk(1,1,0,8'h11, 1,1,1,0,0, 1, 8'h11));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 1, 8'h11));
    vecs.push_back(mk(1,1,0,8'h22, 1,1,1,0,0, 2, 8'h22));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 2, 8'h22));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 2, 8'h22));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0,0,0, 2, 8'h22));

    foreach (vecs[i]) begin
      reset     = vecs[i].rst_n;
      des_ready = vecs[i].rdy;
      des_data  = vecs[i].din;
      rd_req    = vecs[i].rd;
      tick();
      act = {state, des_ack, fifo_enq, fifo_deq, rd_valid, occ,
             full, empty, des_write, fifo_data};
      exp = {vecs[i].st, vecs[i].ack, vecs[i].enq, vecs[i].deq, vecs[i].vld,
             vecs[i].occ, vecs[i].full, vecs[i].empty, vecs[i].wr, vecs[i].fdata};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
    end
    chk("drop_cnt_stall_policy", 32'(drop_cnt), 32'd0);

    // ---- length check ----
    chk("len_err_clean", 32'(len_err), 32'd0);
    force_len = 1'b1;
    len_val   = 4'd3;
    tick();
    tick();
    chk("len_err_set", 32'(len_err), 32'd1);
    force_len = 1'b0;
    tick();
    tick();
    tick();
    chk("len_err_sticky", 32'(len_err), 32'd1);

    // ---- reset while in ACK ----
    des_ready = 1'b1;
    des_data  = 8'h44;
    tick();
    chk("pre_reset_ack", 32'({state, des_ack, fifo_enq, occ}), 32'({2'd1, 1'b1, 1'b1, 4'd3}));
    reset = 1'b0;
    tick();
    chk("reset_mid_ack", 32'({state, occ, des_ack, fifo_enq, des_write, empty, fifo_data}),
        32'({2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}));
    chk("reset_clears_len_err", 32'(len_err), 32'd0);
    reset     = 1'b1;
    des_ready = 1'b0;
    tick();
    chk("des_write_after_reset", 32'({des_write, state, des_ack}), 32'({1'b1, 2'd0, 1'b0}));

    // ---- drop policy instance ----
    for (int b = 1; b <= 8; b++) begin
      b_ready = 1'b1;
      b_data  = 8'(b + 8'h40);
      tick();
      b_ready = 1'b0;
      tick();
    end
    chk("drop_fill", 32'({b_occ, b_full, b_write}), 32'({4'd8, 1'b1, 1'b0}));
    b_enq_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      b_ready = 1'b1;
      b_data  = 8'(i);
      tick();
      b_enq_seen = b_enq_seen | b_enq;
      if (i <= 3) chk($sformatf("drop_ack%0d", i), 32'({b_state, b_ack, b_enq}), 32'({2'd1, 1'b1, 1'b0}));
      b_ready = 1'b0;
      tick();
      b_enq_seen = b_enq_seen | b_enq;
      if (i == 3)   chk("drop_cnt3", 32'({b_drop, b_occ}), 32'({8'd3, 4'd8}));
      if (i == 254) chk("drop_cnt254", 32'(b_drop), 32'd254);
      if (i == 255) chk("drop_cnt255", 32'(b_drop), 32'd255);
    end
    chk("drop_cnt_sat", 32'({b_drop, b_occ, b_state}), 32'({8'd255, 4'd8, 2'd0}));
    chk("drop_no_enq", 32'(b_enq_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
